ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Parametrised multi-cycle execute unit for the RV32M extension: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Sits beside the single-cycle EX ALU in the EX stage. ID_EX issues M-extension ops to it through a valid/ready handshake.
- The result leaves on the same modify_flag/modify_address/modify_data triple that EX drives toward EX_MEM.
- Iterative shift-add multiply and restoring divide. Processes STEP bits per cycle, so area trades against latency.

Parameters:
XLEN, 32, operand and result width; must be a multiple of STEP.
STEP, 1, bits processed per CALC cycle; legal values 1, 2, 4.
REG_ADDR_W, 5, width of the destination register address carried with the op.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
flush  in  1  synchronous discard on branch misprediction (br_error); aborts the op in flight.
in_valid  in  1  operation offered.
in_ready  out  1  unit can accept; equals (state==IDLE).
op  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
op1  in  XLEN  rs1 value.
op2  in  XLEN  rs2 value.
write_flag  in  1  writeback enable, carried with the op.
dest_address  in  REG_ADDR_W  rd, carried with the op.
out_valid  out  1  result held on the modify_* outputs.
out_ready  in  1  downstream consumes the result.
modify_flag  out  1  registered write_flag of the completed op.
modify_address  out  REG_ADDR_W  registered rd.
modify_data  out  XLEN  result.

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE. in_ready=1 after the reset settles; out_valid=0, modify_flag=0, modify_address=0, modify_data=0. The counter and all datapath registers are cleared.
- States:
  - IDLE: in_ready=1. On in_valid&&!flush, latch op, write_flag and dest_address.
    - Operands are stored as magnitudes. A signed operand is negated when its MSB is 1. MULHSU treats op1 as signed and op2 as unsigned. MULHU and DIVU/REMU treat both as unsigned. MUL treats both as signed; low bits are sign-agnostic.
    - Record the result sign:
      - MUL*: XOR of the operand signs.
      - DIV: XOR of the operand signs.
      - REM: sign of the dividend.
    - Set counter=XLEN/STEP and go to CALC, or take one of the special cases below.
  - Divide special cases bypass CALC and go straight to DONE:
    - op2==0: DIV/DIVU give quotient all-ones; REM/REMU give remainder = op1.
    - DIV/REM with op1=1<<(XLEN-1) and op2=all-ones: quotient = op1, remainder = 0.
  - CALC: each edge processes STEP bits and decrements counter.
    - Multiply uses a 2*XLEN accumulator.
    - Divide is restoring: shift the remainder, subtract the divisor, keep the result if non-negative, and set the quotient bit.
    - When counter reaches 1, the edge applies the sign correction (two's-complement negate if needed) and selects the result. It goes to DONE with out_valid=1.
    - Result selection: MUL takes low XLEN bits; MULH, MULHSU and MULHU take high XLEN bits; DIV* takes the quotient; REM* takes the remainder.
  - DONE: out_valid=1; the modify_* outputs are stable. On out_ready, go to IDLE with out_valid=0 on the same edge. No new op is accepted in DONE (in_ready=0).
- Latency: for an op accepted at edge t, out_valid rises after edge t+XLEN/STEP (32 cycles at defaults, 8 with STEP=4). Special cases rise after edge t+1... more precisely, they take the DONE state at edge t, so out_valid is visible in the cycle after acceptance.
- Throughput: one op per (latency+1) cycles at best. The result is held indefinitely while out_ready=0.
- flush: from any state, the next edge goes to IDLE with out_valid=0 and modify_flag=0. flush beats in_valid and out_ready in the same cycle, so no op is accepted.
- Reset mid-CALC or mid-DONE aborts immediately. No partial result appears.
- The modify_* outputs change only on the edge entering DONE, on flush, or on reset. They keep their last value in IDLE, but modify_flag is cleared on leaving DONE.
- Internal widths: the accumulator is 2*XLEN. The remainder register is XLEN+1 bits so the subtract carry/borrow is available. Counter width is clog2(XLEN/STEP)+1.

Test Plan:
- MUL, XLEN=32, STEP=1: op1=0xFFFFFFFF (-1), op2=7, rd=5 -> out_valid exactly 32 cycles after accept; modify_data=0xFFFFFFF9, modify_address=5, modify_flag=1.
- MULH/MULHSU/MULHU with op1=0x80000000, op2=0xFFFFFFFF:
  - MULH -> 0x00000000
  - MULHSU -> 0x80000000
  - MULHU -> 0x7FFFFFFF
- DIV op1=-7 (0xFFFFFFF9), op2=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Special cases, each with out_valid in the cycle after accept:
  - DIV x/0 with op1=123 -> 0xFFFFFFFF. REMU 123/0 -> 123.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0.
- Handshake/flush:
  - Hold out_ready=0 for 10 cycles after out_valid -> data stable and in_ready=0; release -> in_ready=1 on the next cycle.
  - Assert flush in CALC cycle 10 together with in_valid -> out_valid never rises and no op is accepted that cycle; a new op on the following cycle completes normally.
- Parametrised run with STEP=4 and random op/operand pairs (including 0, 1, -1, MIN) checked against a reference model -> all results match and latency=8. Asynchronous rst pulse mid-CALC -> out_valid=0 and in_ready=1 immediately after deassertion.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide execute unit: shift-add multiply and restoring divide,
// STEP bits per cycle, result presented on the EX modify_flag/modify_address/modify_data triple.
module ex_muldiv_unit #(
   parameter int XLEN       = 32,
   parameter int STEP       = 1,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            op,
   input  logic [XLEN-1:0]       op1,
   input  logic [XLEN-1:0]       op2,
   input  logic                  write_flag,
   input  logic [REG_ADDR_W-1:0] dest_address,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  modify_flag,
   output logic [REG_ADDR_W-1:0] modify_address,
   output logic [XLEN-1:0]       modify_data
);
   localparam int ITERS = XLEN / STEP;
   localparam int CNT_W = $clog2(ITERS) + 1;
   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_nxt;

   logic [2:0]            op_q;
   logic                  neg_q;
   logic                  wf_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic [XLEN-1:0]       b_q;
   logic [2*XLEN-1:0]     acc_q, acc_nxt, prod;
   logic [XLEN:0]         rem_q, rem_nxt, sum;
   logic [XLEN+1:0]       trial;
   logic [CNT_W-1:0]      cnt_q;
   logic [XLEN-1:0]       result;

   logic                  sgn_a, sgn_b, neg_in, div_zero, div_ovf, special;
   logic [XLEN-1:0]       mag_a, mag_b, special_val;

   function automatic logic [2*XLEN-1:0] sign_fix(input logic [2*XLEN-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

   // Operand decode at issue: magnitudes, result sign and the divide corner cases
   always_comb begin
      sgn_a       = op1[XLEN-1] && (op != 3'd3) && (op != 3'd5) && (op != 3'd7);
      sgn_b       = op2[XLEN-1] && (op == 3'd0 || op == 3'd1 || op == 3'd4 || op == 3'd6);
      mag_a       = sgn_a ? -op1 : op1;
      mag_b       = sgn_b ? -op2 : op2;
      neg_in      = (op == 3'd6) ? sgn_a : (sgn_a ^ sgn_b);
      div_zero    = op[2] && (op2 == '0);
      div_ovf     = (op == 3'd4 || op == 3'd6) && (op1 == MIN_VAL) && (op2 == '1);
      special     = div_zero || div_ovf;
      special_val = div_zero ? (op[1] ? op1 : '1) : (op[1] ? '0 : op1);
   end

   // Iteration: acc low half holds multiplier / dividend-then-quotient
   always_comb begin
      acc_nxt = acc_q;
      rem_nxt = rem_q;
      sum     = '0;
      trial   = '0;
      for (int i = 0; i < STEP; i++) begin
         if (op_q[2]) begin
            rem_nxt = {rem_nxt[XLEN-1:0], acc_nxt[XLEN-1]};
            acc_nxt = {acc_nxt[2*XLEN-1:XLEN], acc_nxt[XLEN-2:0], 1'b0};
            trial   = {1'b0, rem_nxt} - {2'b00, b_q};
            if (!trial[XLEN+1]) begin
               rem_nxt    = trial[XLEN:0];
               acc_nxt[0] = 1'b1;
            end
         end else begin
            sum     = {1'b0, acc_nxt[2*XLEN-1:XLEN]} + (acc_nxt[0] ? {1'b0, b_q} : '0);
            acc_nxt = {sum, acc_nxt[XLEN-1:1]};
         end
      end
      prod = sign_fix(acc_nxt, neg_q);
      case (op_q)
         3'd0:             result = prod[XLEN-1:0];
         3'd1, 3'd2, 3'd3: result = prod[2*XLEN-1:XLEN];
         3'd4, 3'd5:       result = prod[XLEN-1:0];
         default: begin
            prod   = sign_fix({{(XLEN-1){1'b0}}, rem_nxt}, neg_q);
            result = prod[XLEN-1:0];
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = special ? DONE : CALC;
         CALC:    if (cnt_q == CNT_W'(1)) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q           <= '0;
         neg_q          <= 1'b0;
         wf_q           <= 1'b0;
         rd_q           <= '0;
         b_q            <= '0;
         acc_q          <= '0;
         rem_q          <= '0;
         cnt_q          <= '0;
         modify_flag    <= 1'b0;
         modify_address <= '0;
         modify_data    <= '0;
      end else if (flush) begin
         modify_flag <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               op_q  <= op;
               neg_q <= neg_in;
               wf_q  <= write_flag;
               rd_q  <= dest_address;
               b_q   <= mag_b;
               acc_q <= {{XLEN{1'b0}}, mag_a};
               rem_q <= '0;
               cnt_q <= CNT_W'(ITERS);
               if (special) begin
                  modify_flag    <= write_flag;
                  modify_address <= dest_address;
                  modify_data    <= special_val;
               end
            end
            CALC: begin
               acc_q <= acc_nxt;
               rem_q <= rem_nxt;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  modify_flag    <= wf_q;
                  modify_address <= rd_q;
                  modify_data    <= result;
               end
            end
            DONE:    if (out_ready) modify_flag <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: STEP=1 and STEP=4 instances against an arithmetic reference model.
module tb_ex_muldiv_unit;
   logic clk = 1'b0;
   logic rst;
   logic flush[2], in_valid[2], in_ready[2], wflag[2], out_valid[2], out_ready[2], mflag[2];
   logic [2:0]  op[2];
   logic [31:0] op1[2], op2[2], mdata[2];
   logic [4:0]  dest[2], maddr[2];
   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ex_muldiv_unit #(.XLEN(32), .STEP(1), .REG_ADDR_W(5)) u_step1 (
      .clk(clk), .rst(rst), .flush(flush[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .op(op[0]), .op1(op1[0]), .op2(op2[0]), .write_flag(wflag[0]), .dest_address(dest[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .modify_flag(mflag[0]),
      .modify_address(maddr[0]), .modify_data(mdata[0]));

   ex_muldiv_unit #(.XLEN(32), .STEP(4), .REG_ADDR_W(5)) u_step4 (
      .clk(clk), .rst(rst), .flush(flush[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .op(op[1]), .op1(op1[1]), .op2(op2[1]), .write_flag(wflag[1]), .dest_address(dest[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .modify_flag(mflag[1]),
      .modify_address(maddr[1]), .modify_data(mdata[1]));

   // Architectural RV32M result computed with 64-bit integer arithmetic
   function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ub, p;
      logic [63:0] pu;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'h0, b});
      case (o)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin pu = 64'(a) * 64'(b); return pu[63:32]; end
         3'd4: begin
            if (b == 32'h0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 32'h0) return 32'hFFFFFFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 32'h0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 32'h0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      return (o[2] && b == 32'h0) || ((o == 3'd4 || o == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF);
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         default: return $urandom();
      endcase
   endfunction

   // Issue one op (caller sits just after an edge), wait for out_valid within a bound,
   // capture the outputs and optionally consume. lat counts edges from accept to DONE.
   task automatic run_op(input int u, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic wf, input bit consume,
                         output logic [31:0] d, output logic [4:0] ad, output logic fl, output int lat);
      in_valid[u] = 1'b1; op[u] = o; op1[u] = a; op2[u] = b; dest[u] = rd; wflag[u] = wf;
      @(posedge clk); #1;
      in_valid[u] = 1'b0;
      lat = 0;
      while (out_valid[u] !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      d = mdata[u]; ad = maddr[u]; fl = mflag[u];
      if (consume) begin
         out_ready[u] = 1'b1;
         @(posedge clk); #1;
         out_ready[u] = 1'b0;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      @(posedge clk); #1;
      for (int u = 0; u < 2; u++) begin
         n_checks++; if (in_ready[u] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", u, in_ready[u]); end
         n_checks++; if (out_valid[u] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", u, out_valid[u]); end
         n_checks++; if (mflag[u] !== 1'b0) begin n_fail++; $display("FAIL reset_flag[%0d]: got %b expected 0", u, mflag[u]); end
         n_checks++; if (maddr[u] !== 5'd0) begin n_fail++; $display("FAIL reset_addr[%0d]: got %h expected 0", u, maddr[u]); end
         n_checks++; if (mdata[u] !== 32'h0) begin n_fail++; $display("FAIL reset_data[%0d]: got %h expected 0", u, mdata[u]); end
      end
      rst = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready[0]); end
   endtask

   task automatic test_mul;
      logic [31:0] d; logic [4:0] ad; logic fl; int lat;
      run_op(0, 3'd0, 32'hFFFFFFFF, 32'd7, 5'd5, 1'b1, 1'b1, d, ad, fl, lat);
      n_checks++; if (d !== 32'hFFFFFFF9) begin n_fail++; $display("FAIL mul_data: got %h expected fffffff9", d); end
      n_checks++; if (ad !== 5'd5) begin n_fail++; $display("FAIL mul_addr: got %0d expected 5", ad); end
      n_checks++; if (fl !== 1'b1) begin n_fail++; $display("FAIL mul_flag: got %b expected 1", fl); end
      n_checks++; if (lat != 32) begin n_fail++; $display("FAIL mul_latency: got %0d expected 32", lat); end
      n_checks++; if (in_ready[0] !== 1'b1 || mflag[0] !== 1'b0) begin n_fail++; $display("FAIL mul_release: in_ready %b flag %b expected 1 0", in_ready[0], mflag[0]); end
   endtask

   task automatic test_arith;
      logic [2:0]  t_op[7]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7};
      logic [31:0] t_a[7]   = '{32'h80000000, 32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
      logic [31:0] t_b[7]   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd7, 32'd7};
      logic [31:0] t_exp[7] = '{32'h0, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
      logic [31:0] d; logic [4:0] ad; logic fl; int lat;
      for (int i = 0; i < 7; i++) begin
         run_op(0, t_op[i], t_a[i], t_b[i], 5'(i + 10), 1'b1, 1'b1, d, ad, fl, lat);
         n_checks++; if (d !== t_exp[i]) begin n_fail++; $display("FAIL arith_data op%0d: got %h expected %h", t_op[i], d, t_exp[i]); end
         n_checks++; if (ad !== 5'(i + 10) || lat != 32) begin n_fail++; $display("FAIL arith_addr_lat op%0d: got %0d/%0d expected %0d/32", t_op[i], ad, lat, i + 10); end
      end
   endtask

   task automatic test_special;
      logic [2:0]  t_op[4]  = '{3'd4, 3'd7, 3'd4, 3'd6};
      logic [31:0] t_a[4]   = '{32'd123, 32'd123, 32'h80000000, 32'h80000000};
      logic [31:0] t_b[4]   = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [31:0] t_exp[4] = '{32'hFFFFFFFF, 32'd123, 32'h80000000, 32'h0};
      logic [31:0] d; logic [4:0] ad; logic fl; int lat;
      for (int i = 0; i < 4; i++) begin
         run_op(0, t_op[i], t_a[i], t_b[i], 5'(i + 20), 1'b1, 1'b1, d, ad, fl, lat);
         n_checks++; if (d !== t_exp[i]) begin n_fail++; $display("FAIL special_data %0d: got %h expected %h", i, d, t_exp[i]); end
         n_checks++; if (lat != 0) begin n_fail++; $display("FAIL special_latency %0d: got %0d expected 0", i, lat); end
         n_checks++; if (fl !== 1'b1 || ad !== 5'(i + 20)) begin n_fail++; $display("FAIL special_tag %0d: got %b/%0d expected 1/%0d", i, fl, ad, i + 20); end
      end
   endtask

   task automatic test_hold;
      logic [31:0] d; logic [4:0] ad; logic fl; int lat;
      run_op(0, 3'd3, 32'hDEADBEEF, 32'h12345678, 5'd9, 1'b1, 1'b0, d, ad, fl, lat);
      n_checks++; if (d !== ref_md(3'd3, 32'hDEADBEEF, 32'h12345678)) begin n_fail++; $display("FAIL hold_data: got %h expected %h", d, ref_md(3'd3, 32'hDEADBEEF, 32'h12345678)); end
      repeat (10) begin
         @(posedge clk); #1;
         n_checks++;
         if (mdata[0] !== d || in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1) begin
            n_fail++; $display("FAIL hold_stable: data %h in_ready %b out_valid %b expected %h 0 1", mdata[0], in_ready[0], out_valid[0], d);
         end
      end
      out_ready[0] = 1'b1;
      @(posedge clk); #1;
      out_ready[0] = 1'b0;
      n_checks++; if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || mflag[0] !== 1'b0) begin
         n_fail++; $display("FAIL hold_release: in_ready %b out_valid %b flag %b expected 1 0 0", in_ready[0], out_valid[0], mflag[0]);
      end
   endtask

   task automatic test_flush;
      logic [31:0] d; logic [4:0] ad; logic fl; int lat; bit seen;
      in_valid[0] = 1'b1; op[0] = 3'd0; op1[0] = 32'd3; op2[0] = 32'd5; dest[0] = 5'd1; wflag[0] = 1'b1;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      flush[0] = 1'b1; in_valid[0] = 1'b1; op1[0] = 32'd11; op2[0] = 32'd13; dest[0] = 5'd2;
      @(posedge clk); #1;
      flush[0] = 1'b0; in_valid[0] = 1'b0;
      n_checks++; if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || mflag[0] !== 1'b0) begin
         n_fail++; $display("FAIL flush_abort: out_valid %b in_ready %b flag %b expected 0 1 0", out_valid[0], in_ready[0], mflag[0]);
      end
      seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; if (out_valid[0] === 1'b1) seen = 1'b1; end
      n_checks++; if (seen) begin n_fail++; $display("FAIL flush_no_result: got out_valid 1 expected 0"); end
      run_op(0, 3'd0, 32'd11, 32'd13, 5'd2, 1'b1, 1'b1, d, ad, fl, lat);
      n_checks++; if (d !== 32'd143 || lat != 32) begin n_fail++; $display("FAIL flush_next_op: got %h/%0d expected 0000008f/32", d, lat); end
   endtask

   task automatic test_random;
      logic [31:0] d, a, b, e; logic [4:0] ad, rd; logic fl, wf; logic [2:0] o; int lat, el;
      for (int i = 0; i < 48; i++) begin
         automatic int u = (i < 8) ? 0 : 1;
         o = 3'($urandom_range(0, 7)); a = pick(); b = pick();
         rd = 5'($urandom_range(0, 31)); wf = 1'($urandom_range(0, 1));
         e  = ref_md(o, a, b);
         el = is_special(o, a, b) ? 0 : ((u == 0) ? 32 : 8);
         run_op(u, o, a, b, rd, wf, 1'b1, d, ad, fl, lat);
         n_checks++; if (d !== e) begin n_fail++; $display("FAIL rand_data u%0d op%0d %h,%h: got %h expected %h", u, o, a, b, d, e); end
         n_checks++; if (lat != el) begin n_fail++; $display("FAIL rand_latency u%0d op%0d: got %0d expected %0d", u, o, lat, el); end
         n_checks++; if (ad !== rd || fl !== wf) begin n_fail++; $display("FAIL rand_tag u%0d: got %0d/%b expected %0d/%b", u, ad, fl, rd, wf); end
      end
   endtask

   task automatic test_async_reset;
      bit seen;
      in_valid[1] = 1'b1; op[1] = 3'd0; op1[1] = 32'd3; op2[1] = 32'd5; dest[1] = 5'd7; wflag[1] = 1'b1;
      @(posedge clk); #1;
      in_valid[1] = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      #2 rst = 1'b1;
      #1;
      n_checks++; if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1 || mdata[1] !== 32'h0) begin
         n_fail++; $display("FAIL async_reset: out_valid %b in_ready %b data %h expected 0 1 0", out_valid[1], in_ready[1], mdata[1]);
      end
      #2 rst = 1'b0;
      #1;
      n_checks++; if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1) begin
         n_fail++; $display("FAIL async_release: out_valid %b in_ready %b expected 0 1", out_valid[1], in_ready[1]);
      end
      seen = 1'b0;
      repeat (12) begin @(posedge clk); #1; if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1) seen = 1'b1; end
      n_checks++; if (seen) begin n_fail++; $display("FAIL async_no_partial: got activity expected idle"); end
   endtask

   initial begin
      rst = 1'b1;
      for (int u = 0; u < 2; u++) begin
         flush[u] = 1'b0; in_valid[u] = 1'b0; out_ready[u] = 1'b0; wflag[u] = 1'b0;
         op[u] = 3'd0; op1[u] = 32'h0; op2[u] = 32'h0; dest[u] = 5'd0;
      end
      test_reset;
      test_mul;
      test_arith;
      test_special;
      test_hold;
      test_flush;
      test_random;
      test_async_reset;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
